// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, default datapath width and the
// state encoding of the operation sequencer.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 3'd0;
    localparam alu_op_t ALU_OP_SUB = 3'd1;
    localparam alu_op_t ALU_OP_AND = 3'd2;
    localparam alu_op_t ALU_OP_OR  = 3'd3;
    localparam alu_op_t ALU_OP_XOR = 3'd4;
    localparam alu_op_t ALU_OP_NOT = 3'd5;
    localparam alu_op_t ALU_OP_SHL = 3'd6;
    localparam alu_op_t ALU_OP_SHR = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Settle counter wide enough for SETTLE_CYCLES up to 15.
    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/alu_operand_regs.sv
// Operand A/B holding registers loaded from the shared bus; the parent
// gates the load enables so the operands freeze while an operation runs.
module alu_operand_regs
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b
);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_a <= '0;
            operand_b <= '0;
        end else begin
            if (load_a) operand_a <= bus_in;
            if (load_b) operand_b <= bus_in;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation per start: drives held operands with an enable
// window of SETTLE_CYCLES, then captures result, carry and zero flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             use_carry,
    input  logic             set_carry,
    input  logic             clr_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [2:0]       alu_select,
    output logic             alu_enable,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             alu_carry_out,
    input  logic             alu_zero_flag
);

    localparam logic [SETTLE_CNT_W-1:0] CNT_INIT = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]              state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    use_carry_q;
    logic                    idle;

    assign idle = (state == ST_IDLE);

    alu_operand_regs #(.WIDTH(WIDTH)) u_operand_regs (
        .clk       (clk),
        .reset     (reset),
        .load_a    (load_a & idle),
        .load_b    (load_b & idle),
        .bus_in    (bus_in),
        .operand_a (alu_in_1),
        .operand_b (alu_in_2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            alu_select  <= '0;
            use_carry_q <= 1'b0;
            result      <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Forcing happens on the start edge too, so the op sees it.
                    if (clr_carry)      flag_c <= 1'b0;
                    else if (set_carry) flag_c <= 1'b1;
                    if (start) begin
                        alu_select  <= op;
                        use_carry_q <= use_carry;
                        settle_cnt  <= CNT_INIT;
                        state       <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == '0) begin
                        result <= alu_data;
                        flag_c <= alu_carry_out;
                        flag_z <= alu_zero_flag;
                        state  <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        alu_enable = 1'b0;
        case (state)
            ST_DRIVE: begin
                busy       = 1'b1;
                alu_enable = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_carry_in = use_carry_q & flag_c;

endmodule
